// File: rtl/button_debouncer.sv
// Per-bit button debouncer: 2-flop synchronizer, saturating stability counter,
// registered debounced level plus one-cycle press/release strobes.
module button_debouncer #(
   parameter int unsigned WIDTH           = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] raw_buttons,
   output logic [WIDTH-1:0] buttons,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      IDLE     = 1'b0,
      COUNTING = 1'b1
   } state_t;

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] stable_q;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] press_c;
   logic [WIDTH-1:0] release_c;
   logic [WIDTH-1:0] press_q;
   logic [WIDTH-1:0] release_q;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   state_t           state_q [WIDTH];
   state_t           state_d [WIDTH];

   // Synchronizer stages and state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         stable_q  <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i]   <= '0;
            state_q[i] <= IDLE;
         end
      end else begin
         sync1_q   <= raw_buttons;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         press_q   <= press_c;
         release_q <= release_c;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i]   <= cnt_d[i];
            state_q[i] <= state_d[i];
         end
      end
   end

   // Next-state: a bit commits only after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            IDLE: begin
               cnt_d[i] = '0;
               if (sync2_q[i] != stable_q[i]) begin
                  cnt_d[i]   = CNT_W'(1);
                  state_d[i] = COUNTING;
               end
            end
            COUNTING: begin
               if (sync2_q[i] == stable_q[i]) begin
                  cnt_d[i]   = '0;
                  state_d[i] = IDLE;
               end else if (cnt_q[i] == CNT_MAX) begin
                  stable_d[i] = sync2_q[i];
                  cnt_d[i]    = '0;
                  state_d[i]  = IDLE;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               cnt_d[i]   = '0;
               state_d[i] = IDLE;
            end
         endcase
      end
   end

   // Output decode: strobes mark the edge at which the stable level flips.
   always_comb begin
      press_c   = '0;
      release_c = '0;
      press_c   = stable_d & ~stable_q;
      release_c = ~stable_d & stable_q;
   end

   assign buttons       = stable_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with WIDTH=5, DEBOUNCE_CYCLES=4.
module tb_button_debouncer;

   localparam int unsigned WIDTH = 5;
   localparam int unsigned DEB   = 4;

   logic             clk;
   logic             reset_n;
   logic [WIDTH-1:0] raw_buttons;
   logic [WIDTH-1:0] buttons;
   logic [WIDTH-1:0] press_pulse;
   logic [WIDTH-1:0] release_pulse;

   int tests;
   int fails;

   button_debouncer #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .raw_buttons   (raw_buttons),
      .buttons       (buttons),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle; inputs changed afterwards are sampled next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                        input logic [WIDTH-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [WIDTH-1:0] exp_b,
                            input logic [WIDTH-1:0] exp_p, input logic [WIDTH-1:0] exp_r);
      check({tag, ".buttons"}, buttons, exp_b);
      check({tag, ".press"}, press_pulse, exp_p);
      check({tag, ".release"}, release_pulse, exp_r);
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      reset_n     = 1'b0;
      raw_buttons = '0;
      repeat (3) tick();
      check_all("reset", 5'b00000, 5'b00000, 5'b00000);
      reset_n = 1'b1;
      repeat (2) tick();
      check_all("idle", 5'b00000, 5'b00000, 5'b00000);

      // Single press: first sampled at edge k, visible at edge k+5.
      raw_buttons = 5'b00001;
      repeat (5) begin
         tick();
         check_all("press0_wait", 5'b00000, 5'b00000, 5'b00000);
      end
      tick();
      check_all("press0_hit", 5'b00001, 5'b00001, 5'b00000);
      tick();
      check_all("press0_after", 5'b00001, 5'b00000, 5'b00000);

      // Three-cycle glitch on bit 2 is rejected.
      raw_buttons = 5'b00101;
      repeat (3) tick();
      raw_buttons = 5'b00001;
      repeat (10) begin
         tick();
         check_all("glitch2", 5'b00001, 5'b00000, 5'b00000);
      end

      // Release bit 0.
      raw_buttons = 5'b00000;
      repeat (5) begin
         tick();
         check_all("rel0_wait", 5'b00001, 5'b00000, 5'b00000);
      end
      tick();
      check_all("rel0_hit", 5'b00000, 5'b00000, 5'b00001);
      tick();
      check_all("rel0_after", 5'b00000, 5'b00000, 5'b00000);

      // Simultaneous press on three bits.
      raw_buttons = 5'b10101;
      repeat (5) begin
         tick();
         check_all("multi_wait", 5'b00000, 5'b00000, 5'b00000);
      end
      tick();
      check_all("multi_hit", 5'b10101, 5'b10101, 5'b00000);
      tick();
      check_all("multi_after", 5'b10101, 5'b00000, 5'b00000);

      // Release bit 4 only.
      raw_buttons = 5'b00101;
      repeat (5) begin
         tick();
         check_all("rel4_wait", 5'b10101, 5'b00000, 5'b00000);
      end
      tick();
      check_all("rel4_hit", 5'b00101, 5'b00000, 5'b10000);
      tick();
      check_all("rel4_after", 5'b00101, 5'b00000, 5'b00000);

      // Return to all-released before the reset scenario.
      raw_buttons = 5'b00000;
      repeat (8) tick();
      check("clear.buttons", buttons, 5'b00000);

      // Reset mid-count on bit 1: counter reaches 2 after four edges.
      raw_buttons = 5'b00010;
      repeat (4) begin
         tick();
         check_all("pre_rst", 5'b00000, 5'b00000, 5'b00000);
      end
      reset_n = 1'b0;
      tick();
      check_all("mid_rst", 5'b00000, 5'b00000, 5'b00000);
      reset_n = 1'b1;
      repeat (5) begin
         tick();
         check_all("post_rst_wait", 5'b00000, 5'b00000, 5'b00000);
      end
      tick();
      check_all("post_rst_hit", 5'b00010, 5'b00010, 5'b00000);
      tick();
      check_all("post_rst_after", 5'b00010, 5'b00000, 5'b00000);
      repeat (3) begin
         tick();
         check_all("post_rst_hold", 5'b00010, 5'b00000, 5'b00000);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
